// File: rtl/tagger_cfg_master.sv
// Register-bus initiator that programs the tagger partition registers.
// On start_i (idle only) the partition table is captured into shadow registers, then the
// block writes every pat_addr entry, the packed patid registers, the packed addr_conf
// registers and pat_commit=1. It then polls pat_commit until the tagger clears bit 0.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   start_i            start request, taken only while busy_o=0
//   pat_addr_i         per-partition word address
//   patid_i            per-partition patid
//   conf_i             per-partition conf
//   busy_o             sequence in progress
//   done_o             one-cycle end-of-sequence pulse
//   err_o              valid with done_o: bus error or poll timeout
//   reg_req_o          register request (addr, write, wdata, wstrb, valid)
//   reg_rsp_i          register response (rdata, error, ready)
module tagger_cfg_master #(
   parameter int unsigned MAXPARTITION = 2,
   parameter int unsigned PATID_LEN    = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0,
   parameter logic [31:0] OFS_COMMIT   = 32'h0,
   parameter logic [31:0] OFS_ADDR     = 32'h4,
   parameter logic [31:0] OFS_PATID    = 32'(32'h4 + 4 * MAXPARTITION),
   parameter logic [31:0] OFS_CONF     = 32'(OFS_PATID + 4 * ((MAXPARTITION + (32 / PATID_LEN)
                                             - 1) / (32 / PATID_LEN))),
   parameter int unsigned POLL_MAX     = 16,
   parameter type reg_req_t = struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   },
   parameter type reg_rsp_t = struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   }
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  start_i,
   input  logic [MAXPARTITION-1:0][31:0]         pat_addr_i,
   input  logic [MAXPARTITION-1:0][PATID_LEN-1:0] patid_i,
   input  logic [MAXPARTITION-1:0][1:0]          conf_i,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  err_o,
   output reg_req_t                              reg_req_o,
   input  reg_rsp_t                              reg_rsp_i
);

   localparam int unsigned NUM_ENTRY_PER_REG = 32 / PATID_LEN;
   localparam int unsigned NUM_PATID_REG =
      (MAXPARTITION + NUM_ENTRY_PER_REG - 1) / NUM_ENTRY_PER_REG;
   localparam int unsigned NUM_CONF_REG = (MAXPARTITION + 15) / 16;
   // One counter serves every state; MAXPARTITION bounds the patid/conf register counts.
   localparam int unsigned CNT_MAX = (MAXPARTITION > POLL_MAX) ? MAXPARTITION : POLL_MAX;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      StIdle, StWrAddr, StWrPatid, StWrConf, StWrCommit, StPoll, StFin
   } state_e;

   state_e                                state_q, state_d;
   logic [CNT_W-1:0]                      cnt_q, cnt_d;
   logic                                  err_q, err_d;
   logic [MAXPARTITION-1:0][31:0]         addr_q;
   logic [MAXPARTITION-1:0][PATID_LEN-1:0] patid_q;
   logic [MAXPARTITION-1:0][1:0]          conf_q;
   logic [NUM_PATID_REG-1:0][31:0]        patid_reg;
   logic [NUM_CONF_REG-1:0][31:0]         conf_reg;
   reg_req_t                              req;
   logic                                  fire;
   logic                                  last;
   logic                                  unused_rdata;

   assign unused_rdata = ^reg_rsp_i.rdata[31:1];

   // Pack the shadow table into the tagger register layout; unused bits stay zero.
   always_comb begin
      patid_reg = '0;
      conf_reg  = '0;
      for (int p = 0; p < MAXPARTITION; p++) begin
         patid_reg[p / NUM_ENTRY_PER_REG][(p % NUM_ENTRY_PER_REG) * PATID_LEN +: PATID_LEN] =
            patid_q[p];
         conf_reg[p / 16][(p % 16) * 2 +: 2] = conf_q[p];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         patid_q <= '0;
         conf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (state_q == StIdle && start_i) begin
            addr_q  <= pat_addr_i;
            patid_q <= patid_i;
            conf_q  <= conf_i;
         end
      end
   end

   // Request fields depend only on state and counter, so they hold steady across stalls.
   always_comb begin
      req   = '0;
      last  = 1'b0;
      case (state_q)
         StWrAddr: begin
            req.valid = 1'b1;
            req.write = 1'b1;
            req.wstrb = 4'hF;
            req.addr  = BASE_ADDR + OFS_ADDR + (32'(cnt_q) << 2);
            for (int k = 0; k < MAXPARTITION; k++)
               if (cnt_q == CNT_W'(k)) req.wdata = addr_q[k];
            last = (cnt_q == CNT_W'(MAXPARTITION - 1));
         end
         StWrPatid: begin
            req.valid = 1'b1;
            req.write = 1'b1;
            req.wstrb = 4'hF;
            req.addr  = BASE_ADDR + OFS_PATID + (32'(cnt_q) << 2);
            for (int j = 0; j < NUM_PATID_REG; j++)
               if (cnt_q == CNT_W'(j)) req.wdata = patid_reg[j];
            last = (cnt_q == CNT_W'(NUM_PATID_REG - 1));
         end
         StWrConf: begin
            req.valid = 1'b1;
            req.write = 1'b1;
            req.wstrb = 4'hF;
            req.addr  = BASE_ADDR + OFS_CONF + (32'(cnt_q) << 2);
            for (int c = 0; c < NUM_CONF_REG; c++)
               if (cnt_q == CNT_W'(c)) req.wdata = conf_reg[c];
            last = (cnt_q == CNT_W'(NUM_CONF_REG - 1));
         end
         StWrCommit: begin
            req.valid = 1'b1;
            req.write = 1'b1;
            req.wstrb = 4'hF;
            req.addr  = BASE_ADDR + OFS_COMMIT;
            req.wdata = 32'h1;
            last      = 1'b1;
         end
         StPoll: begin
            req.valid = 1'b1;
            req.addr  = BASE_ADDR + OFS_COMMIT;
            last      = (cnt_q == CNT_W'(POLL_MAX - 1));
         end
         default: ;
      endcase
   end

   assign fire = req.valid && reg_rsp_i.ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StWrAddr;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         StFin: state_d = StIdle;
         default: begin
            if (fire) begin
               cnt_d = cnt_q + 1'b1;
               if (reg_rsp_i.error) begin
                  state_d = StFin;
                  err_d   = 1'b1;
               end else if (state_q == StPoll) begin
                  // Commit cleared ends the poll; otherwise the last allowed read times out.
                  if (!reg_rsp_i.rdata[0]) begin
                     state_d = StFin;
                  end else if (last) begin
                     state_d = StFin;
                     err_d   = 1'b1;
                  end
               end else if (last) begin
                  cnt_d = '0;
                  case (state_q)
                     StWrAddr:  state_d = StWrPatid;
                     StWrPatid: state_d = StWrConf;
                     StWrConf:  state_d = StWrCommit;
                     default:   state_d = StPoll;
                  endcase
               end
            end
         end
      endcase
   end

   assign reg_req_o = req;
   assign busy_o    = (state_q != StIdle) && (state_q != StFin);
   assign done_o    = (state_q == StFin);
   assign err_o     = (state_q == StFin) && err_q;

endmodule

// File: tb/tb_tagger_cfg_master.sv
module tb_tagger_cfg_master;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } rsp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT 0: default parameters. DUT 1: five partitions, POLL_MAX=4.
   logic [4:0][31:0] t_addr;
   logic [4:0][7:0]  t_patid;
   logic [4:0][1:0]  t_conf;
   logic start [2];
   logic busy  [2];
   logic done  [2];
   logic err   [2];
   req_t req   [2];
   rsp_t rsp   [2];

   tagger_cfg_master #(.reg_req_t(req_t), .reg_rsp_t(rsp_t)) dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]),
      .pat_addr_i(t_addr[1:0]), .patid_i(t_patid[1:0]), .conf_i(t_conf[1:0]),
      .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
      .reg_req_o(req[0]), .reg_rsp_i(rsp[0])
   );

   tagger_cfg_master #(.MAXPARTITION(5), .POLL_MAX(4), .reg_req_t(req_t), .reg_rsp_t(rsp_t))
   dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]),
      .pat_addr_i(t_addr), .patid_i(t_patid), .conf_i(t_conf),
      .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
      .reg_req_o(req[1]), .reg_rsp_i(rsp[1])
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: the ordered list of accesses the spec requires for the current table.
   int unsigned e_addr [$];
   int unsigned e_data [$];
   bit          e_wr   [$];

   task automatic push(input int unsigned a, input int unsigned d, input bit w);
      e_addr.push_back(a);
      e_data.push_back(d);
      e_wr.push_back(w);
   endtask

   task automatic build_model(input int idx, input int n_ones, input int err_acc,
                              output int n_exp, output bit exp_err);
      int mp   = (idx != 0) ? 5 : 2;
      int pmax = (idx != 0) ? 4 : 16;
      int npr  = (mp + 3) / 4;
      int nrd;
      int unsigned v;
      e_addr.delete();
      e_data.delete();
      e_wr.delete();
      for (int k = 0; k < mp; k++) push(4 + 4 * k, t_addr[k], 1'b1);
      for (int j = 0; j < npr; j++) begin
         v = 0;
         for (int e = 0; e < 4; e++)
            if (j * 4 + e < mp) v = v + (int'(t_patid[j * 4 + e]) << (8 * e));
         push(4 + 4 * mp + 4 * j, v, 1'b1);
      end
      v = 0;
      for (int p = 0; p < mp; p++) v = v + (int'(t_conf[p]) << (2 * p));
      push(4 + 4 * mp + 4 * npr, v, 1'b1);
      push(0, 1, 1'b1);
      nrd = (n_ones + 1 < pmax) ? n_ones + 1 : pmax;
      for (int r = 0; r < nrd; r++) push(0, 0, 1'b0);
      exp_err = (n_ones >= pmax);
      n_exp   = e_addr.size();
      if (err_acc < n_exp) begin
         n_exp   = err_acc + 1;
         exp_err = 1'b1;
      end
   endtask

   task automatic rand_table();
      for (int p = 0; p < 5; p++) begin
         t_addr[p]  = $urandom;
         t_patid[p] = 8'($urandom);
         t_conf[p]  = 2'($urandom);
      end
   endtask

   // Runs one full sequence on DUT idx with a responder that stalls access stall_acc for
   // stall_n cycles, errors access err_acc, and returns commit=1 for the first n_ones reads.
   task automatic run_seq(input int idx, input int n_ones, input int err_acc,
                          input int stall_acc, input int stall_n);
      int n_exp, exp_cyc, cyc, acc, stalls, reads;
      bit exp_err, got, rdy, fire, was_rd;
      build_model(idx, n_ones, err_acc, n_exp, exp_err);
      exp_cyc = n_exp + ((stall_acc < n_exp) ? stall_n : 0) + 1;
      @(negedge clk);
      start[idx] = 1'b1;
      @(negedge clk);
      start[idx] = 1'b0;
      cyc = 1; acc = 0; stalls = 0; reads = 0; got = 1'b0;
      while (!got && cyc < 300) begin
         if (done[idx]) begin
            got = 1'b1;
            start[idx] = 1'b0;
            check("done_cycle", cyc, exp_cyc);
            check("err_at_done", err[idx], exp_err);
            check("access_count", acc, n_exp);
            check("busy_at_done", busy[idx], 1'b0);
            check("valid_at_done", req[idx].valid, 1'b0);
         end else begin
            check("busy", busy[idx], 1'b1);
            check("err_not_done", err[idx], 1'b0);
            if (acc < n_exp) begin
               check("valid", req[idx].valid, 1'b1);
               check("addr", req[idx].addr, e_addr[acc]);
               check("write", req[idx].write, e_wr[acc]);
               check("wstrb", req[idx].wstrb, e_wr[acc] ? 4'hF : 4'h0);
               if (e_wr[acc]) check("wdata", req[idx].wdata, e_data[acc]);
            end else begin
               check("extra_access", req[idx].valid, 1'b0);
            end
            rdy = !(acc == stall_acc && stalls < stall_n);
            if (!rdy) stalls++;
            rsp[idx].ready = rdy;
            rsp[idx].error = (acc == err_acc);
            rsp[idx].rdata = (reads < n_ones) ? 32'h1 : 32'h0;
            fire   = rdy && req[idx].valid;
            was_rd = !req[idx].write;
            // Noise on the table and start while busy must have no effect.
            start[idx] = 1'($urandom);
            t_addr[0]  = $urandom;
            t_patid[0] = 8'($urandom);
            @(negedge clk);
            if (fire) begin
               acc++;
               if (was_rd) reads++;
            end
            cyc++;
         end
      end
      if (!got) check("done_seen", 1'b0, 1'b1);
      start[idx] = 1'b0;
      rsp[idx]   = '0;
      @(negedge clk);
      check("done_pulse_end", done[idx], 1'b0);
      check("idle_busy", busy[idx], 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      rsp[0] = '0;
      rsp[1] = '0;
      t_addr = '0;
      t_patid = '0;
      t_conf = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_req", req[i], '0);
         check("rst_busy", busy[i], 1'b0);
         check("rst_done", done[i], 1'b0);
         check("rst_err", err[i], 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Directed cases on the default configuration.
      t_addr[0] = 32'h1000_0000; t_addr[1] = 32'h2000_0000;
      t_patid[0] = 8'h11; t_patid[1] = 8'h22;
      t_conf[0] = 2'b01; t_conf[1] = 2'b10;
      run_seq(0, 0, 99, 99, 0);
      t_addr[0] = 32'h1000_0000; t_patid[0] = 8'h11;
      run_seq(0, 2, 99, 99, 0);
      t_addr[0] = 32'h1000_0000; t_patid[0] = 8'h11;
      run_seq(0, 0, 99, 1, 3);
      run_seq(0, 0, 2, 99, 0);

      // Five partitions: second patid register holds one entry; poll timeout after 4 reads.
      for (int p = 0; p < 5; p++) t_patid[p] = 8'hFF;
      run_seq(1, 0, 99, 99, 0);
      rand_table();
      run_seq(1, 1000, 99, 99, 0);

      // Reset while the first write is stalled.
      rand_table();
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      rsp[0].ready = 1'b0;
      check("pre_rst_valid", req[0].valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_valid", req[0].valid, 1'b0);
      check("rst_mid_busy", busy[0], 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("rst_mid_done", done[0], 1'b0);
      end
      rst = 1'b0;
      rand_table();
      run_seq(0, 1, 99, 99, 0);

      // Randomized sequences on both configurations.
      for (int it = 0; it < 24; it++) begin
         rand_table();
         run_seq(it % 2, $urandom_range(0, 5), $urandom_range(0, 20),
                 $urandom_range(0, 12), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/tagger_cfg_master.md
Name: tagger_cfg_master

Overview:
- Register-bus initiator that programs the tagger partition registers.
- Takes a partition table of word address, patid and conf per partition, packs it into the tagger register layout, and issues the writes over reg_req_t/reg_rsp_t.
- Writes pat_commit=1, then polls pat_commit until the tagger clears it.
- Sits between a system controller (or boot FSM) and the tagger register port.

Parameters:
- MAXPARTITION, 2, number of partitions.
- PATID_LEN, 8, patid width in bits (1..32).
- BASE_ADDR, 32'h0, byte base address of the tagger register block.
- OFS_COMMIT, 32'h0, pat_commit offset.
- OFS_ADDR, 32'h4, pat_addr[0] offset; entry k is at OFS_ADDR+4k.
- OFS_PATID, 32'h4+4*MAXPARTITION, patid[0] offset; stride 4.
- OFS_CONF, OFS_PATID+4*NUM_PATID_REG, addr_conf[0] offset; stride 4.
- POLL_MAX, 16, maximum commit poll reads before timeout (>=1).
- reg_req_t, logic, request struct with fields addr, write, wdata, wstrb, valid.
- reg_rsp_t, logic, response struct with fields rdata, error, ready.

Derived values:
- NUM_ENTRY_PER_REG = 32/PATID_LEN.
- NUM_PATID_REG = ceil(MAXPARTITION/NUM_ENTRY_PER_REG).
- NUM_CONF_REG = ceil(MAXPARTITION/16).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request to program the table; accepted only when busy_o=0.
- pat_addr_i  in  MAXPARTITION x 32  word address per partition (byte address >> 2).
- patid_i  in  MAXPARTITION x PATID_LEN  patid per partition.
- conf_i  in  MAXPARTITION x 2  conf per partition.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at end of sequence.
- err_o  out  1  qualified by done_o: bus error or poll timeout.
- reg_req_o  out  reg_req_t  register request to the tagger.
- reg_rsp_i  in  reg_rsp_t  register response from the tagger.

Behaviour:
- Reset: all outputs 0, including every reg_req_o field; FSM in IDLE; counters 0.
  - Reset mid-sequence aborts immediately: valid drops even while a request is pending, and no done_o is produced.
- Accept (IDLE, start_i=1): latch all table inputs into shadow registers and set busy_o the next cycle.
  - Inputs are ignored while busy_o=1.
  - start_i during busy is dropped, not queued.
- FSM states: IDLE -> WR_ADDR -> WR_PATID -> WR_CONF -> WR_COMMIT -> POLL -> FIN -> IDLE.
  - WR_ADDR issues MAXPARTITION writes, index k=0 upward. Address BASE_ADDR+OFS_ADDR+4k; wdata = shadow pat_addr[k].
  - WR_PATID issues NUM_PATID_REG writes. Reg j bits [PATID_LEN*e +: PATID_LEN] = patid[j*NUM_ENTRY_PER_REG+e]. Entries with index >= MAXPARTITION and bits above NUM_ENTRY_PER_REG*PATID_LEN are zero.
  - WR_CONF issues NUM_CONF_REG writes. Reg c bits [2e+:2] = conf[16c+e]; unused bits are zero.
  - WR_COMMIT writes 32'h1 to OFS_COMMIT.
  - POLL issues reads of OFS_COMMIT. rdata[0]=0 -> FIN. rdata[0]=1 -> issue another read the next cycle and increment the poll counter. Timeout after POLL_MAX reads, all returning 1.
  - FIN drives done_o=1 for one cycle, err_o per outcome, busy_o=0 the same cycle, then returns to IDLE.
- Request handshake:
  - valid is high in every access state.
  - addr/write/wdata are held stable until a cycle with valid&&ready; that cycle completes the access.
  - The next access's valid is driven the following cycle, back-to-back with no idle gap.
  - wstrb = 4'hF for writes and 4'h0 for reads; write=0 in POLL.
- Errors: reg_rsp_i.error=1 on a completing access, or poll timeout, goes to FIN with err_o=1. No further accesses are issued.
- err_o and done_o are 0 outside the FIN cycle.
- Minimum latency with ready tied high: start at cycle 0; first valid at cycle 1; MAXPARTITION+NUM_PATID_REG+NUM_CONF_REG+1 write cycles; then one read per poll; done_o the cycle after the last completing read.
- Counters are sized $clog2 of the largest index+1, with a minimum width of 1. Counters are cleared on entry to each state.

Test Plan:
- Defaults, responder ready=1, commit reads return 0 on the first poll. Inputs: pat_addr={32'h2000_0000, 32'h1000_0000}, patid={8'h22, 8'h11}, conf={2'b10, 2'b01}.
  -> Writes in order: 0x4<-0x1000_0000, 0x8<-0x2000_0000, 0xC<-0x0000_2211, 0x10<-0x0000_0009, 0x0<-0x1.
  -> Then 1 read; done_o at cycle 7; err_o=0.
- Responder returns commit=1 twice, then 0 -> 3 poll reads; done_o at cycle 9; err_o=0.
- Responder ready low for 3 cycles on the 2nd write -> req fields stable for 4 cycles; sequence otherwise unchanged; done_o at cycle 10.
- error=1 on the WR_PATID write -> no conf/commit accesses; done_o=1 with err_o=1 the next cycle.
- POLL_MAX=4, commit always reads 1 -> exactly 4 reads, then done_o=1, err_o=1.
- rst_i asserted while the first write is pending -> valid=0 asynchronously, busy_o=0, no done_o. After release, a new start_i produces a full correct sequence.
- Also checked: MAXPARTITION=5, PATID_LEN=8 -> NUM_PATID_REG=2, and the 2nd patid reg upper 24 bits are zero.
